// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, address/data types and the
// write-port bundle used by writeback logic.
package regfile_pkg;

  localparam int RF_AW    = 4;
  localparam int RF_DW    = 16;
  localparam int RF_NREGS = 16;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  typedef struct packed {
    logic     load;
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_wr_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching cyclically
// from an internal pointer, then moves the pointer just past the winner.
// No grant is issued while en is low, and the pointer only advances on a grant.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_req;
  logic          w_found;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  assign w_req = en ? req : '0;

  // Cyclic search for the first active request starting at the pointer
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_cand = w_sum[IW-1:0];
      if (!w_found && w_req[w_cand]) begin
        w_found     = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

  // Pointer moves to the requester after the winner, wrapping at N
  always_ff @(posedge clk) begin
    if (clear) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (idx == IW'(N-1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter for the 16x16 register file: NREQ writeback requesters
// compete round-robin with valid/ready handshakes; the winner is captured into
// a registered Load/Caddr/C stage and a one-hot in-flight mask is published.
// Optional macro REGFILE_WR_FWD_EN adds a zero-latency read-after-write bypass
// (fwd_addr_a/b in, fwd_hit_a/b and fwd_data out).
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic                     hold,
`ifdef REGFILE_WR_FWD_EN
  input  logic [AW-1:0]            fwd_addr_a,
  input  logic [AW-1:0]            fwd_addr_b,
  output logic                     fwd_hit_a,
  output logic                     fwd_hit_b,
  output logic [DW-1:0]            fwd_data,
`endif
  output logic                     rf_load,
  output logic [AW-1:0]            rf_caddr,
  output logic [DW-1:0]            rf_c,
  output logic [2**AW-1:0]         inflight_mask,
  output logic [$clog2(NREQ)-1:0]  grant_idx
);

  localparam int IW = $clog2(NREQ);

  logic            w_en;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;

  logic            r_load;
  logic [AW-1:0]   r_caddr;
  logic [DW-1:0]   r_c;
  logic [IW-1:0]   r_gidx;

  // Grants are suppressed during reset and pipeline stalls
  assign w_en = !clear && !hold;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .clk   (clk),
    .clear (clear),
    .req   (req_valid),
    .en    (w_en),
    .gnt   (w_gnt),
    .idx   (w_idx)
  );

  assign req_ready = w_gnt;
  assign w_any     = |w_gnt;

  // Select the granted requester's address and data (one-hot mux)
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*DW +: DW];
      end
    end
  end

  // --- register-file write stage: capture the accepted write for one cycle
  always_ff @(posedge clk) begin
    if (clear) begin
      r_load  <= 1'b0;
      r_caddr <= '0;
      r_c     <= '0;
      r_gidx  <= '0;
    end else if (w_any) begin
      r_load  <= 1'b1;
      r_caddr <= w_addr;
      r_c     <= w_data;
      r_gidx  <= w_idx;
    end else begin
      r_load  <= 1'b0;
    end
  end

  assign rf_load   = r_load;
  assign rf_caddr  = r_caddr;
  assign rf_c      = r_c;
  assign grant_idx = r_gidx;

  // One-hot of the destination register while its write is in flight
  always_comb begin
    inflight_mask = '0;
    if (r_load) inflight_mask[r_caddr] = 1'b1;
  end

`ifdef REGFILE_WR_FWD_EN
  assign fwd_hit_a = r_load && (r_caddr == fwd_addr_a);
  assign fwd_hit_b = r_load && (r_caddr == fwd_addr_b);
  assign fwd_data  = r_c;
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb (NREQ=2, DW=16, AW=4): reference model of the
// arbitration rules plus a register-file image, compared every cycle, with
// directed scenarios carrying literal expectations.
module tb_regfile_wr_arb;

  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int AW   = 4;

  logic                clk = 1'b0;
  logic                clear;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                hold;
  logic                rf_load;
  logic [AW-1:0]       rf_caddr;
  logic [DW-1:0]       rf_c;
  logic [2**AW-1:0]    inflight_mask;
  logic [0:0]          grant_idx;
`ifdef REGFILE_WR_FWD_EN
  logic [AW-1:0]       fwd_addr_a;
  logic [AW-1:0]       fwd_addr_b;
  logic                fwd_hit_a;
  logic                fwd_hit_b;
  logic [DW-1:0]       fwd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wr_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .clear         (clear),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .hold          (hold),
`ifdef REGFILE_WR_FWD_EN
    .fwd_addr_a    (fwd_addr_a),
    .fwd_addr_b    (fwd_addr_b),
    .fwd_hit_a     (fwd_hit_a),
    .fwd_hit_b     (fwd_hit_b),
    .fwd_data      (fwd_data),
`endif
    .rf_load       (rf_load),
    .rf_caddr      (rf_caddr),
    .rf_c          (rf_c),
    .inflight_mask (inflight_mask),
    .grant_idx     (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr  = 0;
  logic        m_load = 1'b0;
  int          m_addr = 0;
  int          m_data = 0;
  int          m_gidx = 0;
  bit          m_init = 1'b0;
  int          m_rf [16];

  // Winner under the round-robin rule, or -1 when nobody is granted
  function automatic int winner(input logic [NREQ-1:0] v, input logic clr,
                                input logic hld, input int p);
    if (clr || hld) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    w = winner(req_valid, clear, hold, m_ptr);
    if (clear) begin
      for (int r = 0; r < 16; r++) m_rf[r] <= 0;
    end else if (m_load) begin
      m_rf[m_addr] <= m_data;
    end
    if (clear) begin
      m_load <= 1'b0; m_addr <= 0; m_data <= 0; m_gidx <= 0; m_ptr <= 0;
      m_init <= 1'b1;
    end else if (w >= 0) begin
      m_load <= 1'b1;
      m_addr <= int'(req_addr[w*AW +: AW]);
      m_data <= int'(req_data[w*DW +: DW]);
      m_gidx <= w;
      m_ptr  <= (w + 1) % NREQ;
    end else begin
      m_load <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    int w;
    if (m_init) begin
      w = winner(req_valid, clear, hold, m_ptr);
      chk("req_ready", 64'(req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
      chk("rf_load", 64'(rf_load), 64'(m_load));
      chk("rf_caddr", 64'(rf_caddr), 64'(m_addr));
      chk("rf_c", 64'(rf_c), 64'(m_data));
      chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
      chk("inflight_mask", 64'(inflight_mask), m_load ? (64'd1 << m_addr) : 64'd0);
`ifdef REGFILE_WR_FWD_EN
      chk("fwd_hit_a", 64'(fwd_hit_a), 64'(m_load && (m_addr == int'(fwd_addr_a))));
      chk("fwd_hit_b", 64'(fwd_hit_b), 64'(m_load && (m_addr == int'(fwd_addr_b))));
      chk("fwd_data", 64'(fwd_data), 64'(m_data));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  typedef struct {
    logic [1:0] v;
    logic       h;
  } pat_t;

  pat_t pats [12] = '{
    '{2'b11, 1'b0}, '{2'b10, 1'b0}, '{2'b01, 1'b1}, '{2'b01, 1'b0},
    '{2'b00, 1'b0}, '{2'b11, 1'b0}, '{2'b11, 1'b1}, '{2'b11, 1'b0},
    '{2'b10, 1'b0}, '{2'b00, 1'b1}, '{2'b11, 1'b0}, '{2'b01, 1'b0}
  };

  initial begin
    clear = 1'b1; hold = 1'b0; req_valid = 2'b11;
    req_addr = '0; req_data = '0;
    set_req(0, 4'd1, 16'h0011);
    set_req(1, 4'd2, 16'h0022);
`ifdef REGFILE_WR_FWD_EN
    fwd_addr_a = 4'd7; fwd_addr_b = 4'd8;
`endif

    // Reset held two cycles with both requesters valid
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_load", 64'(rf_load), 64'd0);
    chk("rst_mask", 64'(inflight_mask), 64'd0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("first_grant", 64'(req_ready), 64'b01);

    // Single write to register 5
    tick();
    req_valid = 2'b01;
    set_req(0, 4'd5, 16'h00AA);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_load", 64'(rf_load), 64'd1);
    chk("single_caddr", 64'(rf_caddr), 64'd5);
    chk("single_c", 64'(rf_c), 64'h00AA);
    chk("single_mask", 64'(inflight_mask), 64'h0020);
    tick();
    @(negedge clk);
    chk("single_rf5", 64'(m_rf[5]), 64'h00AA);
    chk("single_idle", 64'(rf_load), 64'd0);

    // Contention from ptr=0: grants alternate with no bubbles
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = 2'b11;
    set_req(0, 4'd1, 16'h0011);
    set_req(1, 4'd2, 16'h0022);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_ready", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
      if (k > 0) begin
        chk("cont_load", 64'(rf_load), 64'd1);
        chk("cont_c", 64'(rf_c), (k % 2 == 1) ? 64'h11 : 64'h22);
      end
      tick();
    end

    // One-cycle hold during contention
    hold = 1'b1;
    @(negedge clk);
    chk("hold_ready", 64'(req_ready), 64'd0);
    chk("hold_inflight", 64'(rf_load), 64'd1);
    tick();
    hold = 1'b0;
    @(negedge clk);
    chk("hold_drop", 64'(rf_load), 64'd0);
    chk("hold_ptr", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;

    // Same destination from both requesters
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = 2'b11;
    set_req(0, 4'd3, 16'h0001);
    set_req(1, 4'd3, 16'h0002);
    @(negedge clk);
    chk("same_g0", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b10;
    @(negedge clk);
    chk("same_g1", 64'(req_ready), 64'b10);
    chk("same_c0", 64'(rf_c), 64'h0001);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("same_caddr", 64'(rf_caddr), 64'd3);
    chk("same_c1", 64'(rf_c), 64'h0002);
    tick();
    @(negedge clk);
    chk("same_rf3", 64'(m_rf[3]), 64'h0002);

    // Clear while a write is in flight
    req_valid = 2'b01;
    set_req(0, 4'd9, 16'h0055);
    tick();
    clear = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("clr_pending", 64'(rf_load), 64'd1);
    chk("clr_caddr", 64'(rf_caddr), 64'd9);
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_load", 64'(rf_load), 64'd0);
    chk("clr_c", 64'(rf_c), 64'd0);

`ifdef REGFILE_WR_FWD_EN
    // Bypass hit on the in-flight register
    req_valid = 2'b01;
    set_req(0, 4'd7, 16'h1234);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("fwd_a", 64'(fwd_hit_a), 64'd1);
    chk("fwd_b", 64'(fwd_hit_b), 64'd0);
    chk("fwd_d", 64'(fwd_data), 64'h1234);
`endif

    // Mixed valid/hold/withdraw patterns, checked by the model each cycle
    for (int p = 0; p < 12; p++) begin
      req_valid = pats[p].v;
      hold      = pats[p].h;
      set_req(0, 4'(p), 16'(16'h0100 + p));
      set_req(1, 4'(15 - p), 16'(16'h0200 + p));
      tick();
    end
    req_valid = 2'b00;
    hold = 1'b0;
    tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
